audio_adc_deserializer: RTL and testbench
=========================================

Name: audio_adc_deserializer

Overview:
- Front-end stage directly upstream of the NIOS II system's audio input path.
- Oversamples the WM8731 ADC serial lines (BCLK, ADCLRCK, ADCDAT) in the system clock domain and deserializes I2S-format stereo samples.
- Presents each completed left/right frame on a valid/ready interface for the audio consumer.
- Tracks overrun and framing errors in sticky status flags.

Parameters:
- DATA_WIDTH, 16, bits per channel sample (16..24).
- SYNC_STAGES, 2, synchronizer flops per serial input (2..3).
- I2S_DELAY, 1, BCLK rising edges skipped after an LRCK edge before the MSB (1 = I2S, 0 = left-justified).

Ports:
- clk_clk  in  1  system clock, 50 MHz; all logic in this domain.
- reset_reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable.
- clear_status  in  1  one-cycle pulse; clears overrun, overrun_count and frame_error.
- audio_interface_BCLK  in  1  codec bit clock, asynchronous, ≤ 6.25 MHz.
- audio_interface_ADCLRCK  in  1  codec LR clock, asynchronous; low = left, high = right.
- audio_interface_ADCDAT  in  1  codec serial data, asynchronous, MSB first.
- out_left  out  DATA_WIDTH  left sample, two's complement.
- out_right  out  DATA_WIDTH  right sample, two's complement.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts frame.
- overrun  out  1  sticky; a frame was dropped.
- overrun_count  out  8  dropped-frame count, saturating.
- frame_error  out  1  sticky; an LRCK edge arrived before DATA_WIDTH bits were captured.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizers 0, shift register 0.
- Input conditioning:
  - Each serial input passes through SYNC_STAGES flops plus one history flop.
  - bclk_rise = sync & ~hist on BCLK.
  - lr_edge = sync ^ hist on ADCLRCK.
  - ADCDAT is sampled from its synchronized value on the bclk_rise cycle; all three inputs share the same synchronizer depth, so they stay aligned.
- FSM states and transitions:
  - IDLE: wait for lr_edge with enable=1. Latch channel = synchronized LRCK and bit_cnt = 0. Go to SKIP if I2S_DELAY=1, else SHIFT.
  - SKIP: first bclk_rise → SHIFT. That edge's data bit is discarded.
  - SHIFT: each bclk_rise shifts ADCDAT into the LSB and increments bit_cnt. When bit_cnt reaches DATA_WIDTH, store the word into the left or right holding register and go to WAIT.
  - WAIT: further bclk_rise ignored; extra codec bits are truncated. lr_edge → SKIP/SHIFT for the next channel.
- Channel completion:
  - Right-channel word stored while left holding register is valid → frame complete, pushed next cycle.
  - Left word is invalidated after every push.
  - A right word with no valid left (startup mid-frame) is discarded silently; this is not an error.
- Framing error:
  - lr_edge while in SKIP or SHIFT sets frame_error and discards the partial word.
  - A left word captured earlier is also invalidated.
  - The FSM restarts the new channel on that same edge; no lost alignment.
- Output handshake:
  - Output registers update 1 clk after the completing bclk_rise cycle.
  - out_left/out_right are stable while out_valid=1 and out_ready=0.
  - Transfer occurs on a cycle with out_valid & out_ready.
  - Push with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle: load the new frame, out_valid=1.
  - Push with out_valid=1 and out_ready=0: drop the new frame, keep the old one, set overrun, overrun_count++ saturating at 255.
  - No push and transfer: out_valid → 0.
- enable=0:
  - FSM forced to IDLE next cycle; partial words and the left holding register are cleared.
  - A pending output frame is retained and can still be accepted.
- clear_status:
  - Clears all status on the next edge.
  - If an overrun or frame error occurs in the same cycle, the set wins.
- Reset asserted mid-frame clears everything asynchronously. After release, capture resumes at the next lr_edge.
- Throughput: one frame per LRCK period; no backpressure to the codec.

Decomposition:
- Shared package audio_pkg:
  - sample_t (logic [DATA_WIDTH-1:0]).
  - FSM state enum {IDLE, SKIP, SHIFT, WAIT}.
  - OVR_CNT_W = 8.
- One sub-module: audio_sync_edge, an N-stage synchronizer with rise/fall/toggle edge outputs, instantiated three times.

Test Plan:
- I2S 48 kHz frame, BCLK = 64·fs, left = 16'h8001, right = 16'h7FFE, out_ready=1 → one out_valid pulse with out_left = 8001, out_right = 7FFE, 1 clk after the 16th right bit edge.
- out_ready=0 for 3 frames → first frame held unchanged; overrun=1, overrun_count=2; clear_status → overrun=0, count=0.
- LRCK toggles after 10 bits of the left channel → frame_error=1, no output for that frame; the next full frame is output correctly.
- Capture starts mid-right-channel after reset release → first emitted frame is the next complete L/R pair; frame_error stays 0.
- I2S_DELAY=0 with left-justified data 16'hA5A5 / 16'h5A5A → same values captured; 24-bit codec words truncated to the upper 16 bits.
- enable dropped mid-left channel, then raised → no frame from the interrupted period; the next full frame is captured; a pending out_valid frame survives the enable drop.

Source files
------------

// File: rtl/audio_adc_deserializer_pkg.sv
// Shared types, state encoding and helpers for the WM8731 ADC deserializer.
package audio_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int OVR_CNT_W = 8;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      WAIT  = 2'd3
   } state_e;

   function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
      return (v == {OVR_CNT_W{1'b1}}) ? v : v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/audio_adc_deserializer_sync_edge.sv
// N-stage synchronizer for one asynchronous codec line, with a history flop
// that turns the synchronized level into rise/fall/toggle strobes.
module audio_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o,
   output logic toggle_o
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   // Synchronizer chain followed by the history flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{1'b0}};
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign sync_o   = sync_q[STAGES-1];
   assign rise_o   = sync_q[STAGES-1] & ~hist_q;
   assign fall_o   = ~sync_q[STAGES-1] & hist_q;
   assign toggle_o = sync_q[STAGES-1] ^ hist_q;

endmodule

// File: rtl/audio_adc_deserializer.sv
// I2S / left-justified stereo deserializer for the WM8731 ADC, oversampled in
// the system clock domain, with a valid/ready frame output and sticky status.
module audio_adc_deserializer
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int I2S_DELAY   = 1
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   input  logic                  enable,
   input  logic                  clear_status,
   input  logic                  audio_interface_BCLK,
   input  logic                  audio_interface_ADCLRCK,
   input  logic                  audio_interface_ADCDAT,
   output logic [DATA_WIDTH-1:0] out_left,
   output logic [DATA_WIDTH-1:0] out_right,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun,
   output logic [OVR_CNT_W-1:0]  overrun_count,
   output logic                  frame_error
);

   localparam int     CNT_W    = $clog2(DATA_WIDTH + 1);
   localparam state_e START_ST = (I2S_DELAY == 1) ? SKIP : SHIFT;

   logic bclk_sync_s, bclk_rise_s, bclk_fall_s, bclk_tog_s;
   logic lr_sync_s, lr_rise_s, lr_fall_s, lr_edge_s;
   logic dat_sync_s, dat_rise_s, dat_fall_s, dat_tog_s;
   logic unused_s;

   audio_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
      .clk_i(clk_clk), .rst_i(reset_reset), .d_i(audio_interface_BCLK),
      .sync_o(bclk_sync_s), .rise_o(bclk_rise_s), .fall_o(bclk_fall_s), .toggle_o(bclk_tog_s)
   );
   audio_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck (
      .clk_i(clk_clk), .rst_i(reset_reset), .d_i(audio_interface_ADCLRCK),
      .sync_o(lr_sync_s), .rise_o(lr_rise_s), .fall_o(lr_fall_s), .toggle_o(lr_edge_s)
   );
   audio_sync_edge #(.STAGES(SYNC_STAGES)) u_dat (
      .clk_i(clk_clk), .rst_i(reset_reset), .d_i(audio_interface_ADCDAT),
      .sync_o(dat_sync_s), .rise_o(dat_rise_s), .fall_o(dat_fall_s), .toggle_o(dat_tog_s)
   );

   assign unused_s = ^{bclk_sync_s, bclk_fall_s, bclk_tog_s, lr_rise_s, lr_fall_s,
                       dat_rise_s, dat_fall_s, dat_tog_s};

   state_e                  state_q;
   logic                    channel_q;
   logic [CNT_W-1:0]        bit_cnt_q;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic [DATA_WIDTH-1:0]   left_q;
   logic                    left_valid_q;

   logic [DATA_WIDTH-1:0]   word_s;
   logic                    ferr_s;
   logic                    done_s;
   logic                    push_s;

   logic [DATA_WIDTH-1:0]   out_left_q, out_left_d;
   logic [DATA_WIDTH-1:0]   out_right_q, out_right_d;
   logic                    out_valid_q, out_valid_d;
   logic                    overrun_q, overrun_d;
   logic [OVR_CNT_W-1:0]    ovr_cnt_q, ovr_cnt_d;
   logic                    frame_error_q, frame_error_d;

   assign word_s = {shift_q[DATA_WIDTH-2:0], dat_sync_s};

   // Capture events: framing error, word completion and frame push.
   always_comb begin
      ferr_s = 1'b0;
      done_s = 1'b0;
      if (enable) begin
         ferr_s = lr_edge_s && ((state_q == SKIP) || (state_q == SHIFT));
         done_s = (state_q == SHIFT) && bclk_rise_s && !lr_edge_s &&
                  (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
      end else begin
         ferr_s = 1'b0;
         done_s = 1'b0;
      end
      push_s = done_s && channel_q && left_valid_q;
   end

   // Capture FSM: channel alignment, bit shifting and left-word holding.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q      <= IDLE;
         channel_q    <= 1'b0;
         bit_cnt_q    <= {CNT_W{1'b0}};
         shift_q      <= {DATA_WIDTH{1'b0}};
         left_q       <= {DATA_WIDTH{1'b0}};
         left_valid_q <= 1'b0;
      end else if (!enable) begin
         state_q      <= IDLE;
         bit_cnt_q    <= {CNT_W{1'b0}};
         shift_q      <= {DATA_WIDTH{1'b0}};
         left_valid_q <= 1'b0;
      end else if (lr_edge_s && (state_q != IDLE || enable)) begin
         // Every LRCK edge starts the new channel; mid-word it also drops the pending left word.
         channel_q <= lr_sync_s;
         bit_cnt_q <= {CNT_W{1'b0}};
         shift_q   <= {DATA_WIDTH{1'b0}};
         state_q   <= START_ST;
         if (ferr_s) begin
            left_valid_q <= 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= IDLE;
            end
            SKIP: begin
               if (bclk_rise_s) begin
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (bclk_rise_s) begin
                  shift_q   <= word_s;
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  if (done_s) begin
                     state_q <= WAIT;
                     if (channel_q) begin
                        left_valid_q <= 1'b0;
                     end else begin
                        left_q       <= word_s;
                        left_valid_q <= 1'b1;
                     end
                  end
               end
            end
            WAIT: begin
               state_q <= WAIT;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Output handshake and sticky status; a set in the same cycle beats clear_status.
   always_comb begin
      out_left_d    = out_left_q;
      out_right_d   = out_right_q;
      out_valid_d   = out_valid_q;
      overrun_d     = clear_status ? 1'b0 : overrun_q;
      ovr_cnt_d     = clear_status ? {OVR_CNT_W{1'b0}} : ovr_cnt_q;
      frame_error_d = (clear_status ? 1'b0 : frame_error_q) | ferr_s;
      if (push_s) begin
         if (!out_valid_q || out_ready) begin
            out_left_d  = left_q;
            out_right_d = word_s;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
            ovr_cnt_d = sat_inc(ovr_cnt_d);
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output and status registers.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         out_left_q    <= {DATA_WIDTH{1'b0}};
         out_right_q   <= {DATA_WIDTH{1'b0}};
         out_valid_q   <= 1'b0;
         overrun_q     <= 1'b0;
         ovr_cnt_q     <= {OVR_CNT_W{1'b0}};
         frame_error_q <= 1'b0;
      end else begin
         out_left_q    <= out_left_d;
         out_right_q   <= out_right_d;
         out_valid_q   <= out_valid_d;
         overrun_q     <= overrun_d;
         ovr_cnt_q     <= ovr_cnt_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign out_left      = out_left_q;
   assign out_right     = out_right_q;
   assign out_valid     = out_valid_q;
   assign overrun       = overrun_q;
   assign overrun_count = ovr_cnt_q;
   assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Directed bench: a bit-level codec model drives two deserializers (I2S and
// left-justified); expected frames go into a scoreboard queue.
module tb_audio_adc_deserializer;
   import audio_pkg::*;

   localparam int DW = 16;
   localparam int HB = 80;

   logic clk = 1'b0;
   logic rst, en_a, en_b, clr, rdy;
   logic bclk, lrck, dat;
   logic [DW-1:0] l_a, r_a, l_b, r_b;
   logic v_a, v_b, ovr_a, ovr_b, fe_a, fe_b;
   logic [OVR_CNT_W-1:0] cnt_a, cnt_b;

   int total = 0;
   int bad = 0;
   int n_a = 0;
   int n_b = 0;
   int rd_a = 0;
   int rd_b = 0;
   logic [2*DW-1:0] got_a [0:63];
   logic [2*DW-1:0] got_b [0:63];
   logic [2*DW-1:0] exp_q [$];

   always #10 clk = ~clk;

   audio_adc_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .I2S_DELAY(1)) dut_a (
      .clk_clk(clk), .reset_reset(rst), .enable(en_a), .clear_status(clr),
      .audio_interface_BCLK(bclk), .audio_interface_ADCLRCK(lrck), .audio_interface_ADCDAT(dat),
      .out_left(l_a), .out_right(r_a), .out_valid(v_a), .out_ready(rdy),
      .overrun(ovr_a), .overrun_count(cnt_a), .frame_error(fe_a)
   );

   audio_adc_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .I2S_DELAY(0)) dut_b (
      .clk_clk(clk), .reset_reset(rst), .enable(en_b), .clear_status(clr),
      .audio_interface_BCLK(bclk), .audio_interface_ADCLRCK(lrck), .audio_interface_ADCDAT(dat),
      .out_left(l_b), .out_right(r_b), .out_valid(v_b), .out_ready(rdy),
      .overrun(ovr_b), .overrun_count(cnt_b), .frame_error(fe_b)
   );

   // Record every accepted frame from either DUT.
   always @(negedge clk) begin
      if (v_a && rdy) begin
         got_a[n_a % 64] <= {l_a, r_a};
         n_a <= n_a + 1;
      end
      if (v_b && rdy) begin
         got_b[n_b % 64] <= {l_b, r_b};
         n_b <= n_b + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_slot(input logic d);
      bclk = 1'b0;
      dat  = d;
      #HB;
      bclk = 1'b1;
      #HB;
   endtask

   // One LRCK half-period: optional junk bit, nb data bits MSB first, then padding.
   task automatic send_chan(input logic lr, input logic [31:0] w, input int nb,
                            input int dly, input int slot);
      logic d;
      lrck = lr;
      for (int p = 0; p < slot; p++) begin
         if (p < dly) d = ~w[31];
         else if (p - dly < nb) d = w[31 - (p - dly)];
         else d = p[0];
         bit_slot(d);
      end
   endtask

   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                             input int nb, input int dly);
      send_chan(1'b0, lw, nb, dly, 32);
      send_chan(1'b1, rw, nb, dly, 32);
   endtask

   // Pop the scoreboard against everything the selected DUT emitted.
   task automatic drain(input bit b);
      int have;
      logic [2*DW-1:0] g;
      logic [2*DW-1:0] e;
      tick(4);
      have = b ? (n_b - rd_b) : (n_a - rd_a);
      chk(b ? "frame_count_b" : "frame_count_a", 32'(have), 32'(exp_q.size()));
      for (int k = 0; k < have && exp_q.size() > 0; k++) begin
         g = b ? got_b[rd_b % 64] : got_a[rd_a % 64];
         if (b) rd_b++; else rd_a++;
         e = exp_q.pop_front();
         chk(b ? "frame_data_b" : "frame_data_a", g, e);
      end
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; en_a = 1'b0; en_b = 1'b0; clr = 1'b0; rdy = 1'b1;
      bclk = 1'b1; lrck = 1'b0; dat = 1'b0;
      tick(5);
      chk("rst_valid_a", 32'(v_a), 32'd0);
      chk("rst_left_a", 32'(l_a), 32'd0);
      chk("rst_ovr_a", 32'(ovr_a), 32'd0);
      chk("rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("rst_fe_a", 32'(fe_a), 32'd0);
      chk("rst_valid_b", 32'(v_b), 32'd0);
      rst = 1'b0;
      tick(5);
      en_a = 1'b1;

      // Startup in the middle of a right channel, then the first full frame.
      send_chan(1'b1, 32'hDEAD0000, 16, 1, 32);
      exp_q.push_back(32'h80017FFE);
      send_frame(32'h80010000, 32'h7FFE0000, 16, 1);
      exp_q.push_back(32'h1234FEDC);
      send_frame(32'h12340000, 32'hFEDC0000, 16, 1);
      exp_q.push_back(32'h0000FFFF);
      send_frame(32'h00000000, 32'hFFFF0000, 16, 1);
      drain(1'b0);
      chk("startup_fe_a", 32'(fe_a), 32'd0);

      // Backpressure across three frames.
      rdy = 1'b0;
      exp_q.push_back(32'hA1B2C3D4);
      send_frame(32'hA1B20000, 32'hC3D40000, 16, 1);
      send_frame(32'h11110000, 32'h22220000, 16, 1);
      send_frame(32'h33330000, 32'h44440000, 16, 1);
      tick(2);
      chk("bp_valid", 32'(v_a), 32'd1);
      chk("bp_left_held", 32'(l_a), 32'h0000A1B2);
      chk("bp_right_held", 32'(r_a), 32'h0000C3D4);
      chk("bp_overrun", 32'(ovr_a), 32'd1);
      chk("bp_count", 32'(cnt_a), 32'd2);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
      chk("clr_overrun", 32'(ovr_a), 32'd0);
      chk("clr_count", 32'(cnt_a), 32'd0);
      rdy = 1'b1;
      drain(1'b0);

      // LRCK toggles after 10 left bits.
      send_chan(1'b0, 32'h55550000, 16, 1, 11);
      send_chan(1'b1, 32'h66660000, 16, 1, 32);
      drain(1'b0);
      chk("ferr_flag", 32'(fe_a), 32'd1);
      exp_q.push_back(32'h0F0FF0F0);
      send_frame(32'h0F0F0000, 32'hF0F00000, 16, 1);
      drain(1'b0);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
      chk("ferr_clr", 32'(fe_a), 32'd0);

      // 24-bit codec words on the I2S instance.
      exp_q.push_back(32'hABCD1234);
      send_frame(32'hABCDEF00, 32'h12345600, 24, 1);
      drain(1'b0);

      // Enable drop mid-left with a pending frame.
      rdy = 1'b0;
      exp_q.push_back(32'h13572468);
      send_frame(32'h13570000, 32'h24680000, 16, 1);
      send_chan(1'b0, 32'h77770000, 16, 1, 8);
      tick(1);
      en_a = 1'b0;
      tick(10);
      chk("en_pending_valid", 32'(v_a), 32'd1);
      chk("en_pending_left", 32'(l_a), 32'h00001357);
      en_a = 1'b1;
      tick(2);
      rdy = 1'b1;
      tick(3);
      send_chan(1'b1, 32'h88880000, 16, 1, 32);
      exp_q.push_back(32'h9ABCDEF0);
      send_frame(32'h9ABC0000, 32'hDEF00000, 16, 1);
      drain(1'b0);
      chk("en_fe_a", 32'(fe_a), 32'd0);

      // Left-justified instance.
      tick(1);
      en_a = 1'b0;
      en_b = 1'b1;
      tick(5);
      exp_q.push_back(32'hA5A55A5A);
      send_frame(32'hA5A50000, 32'h5A5A0000, 16, 0);
      exp_q.push_back(32'hC3C33C3C);
      send_frame(32'hC3C3C300, 32'h3C3C3C00, 24, 0);
      drain(1'b1);
      chk("lj_fe_b", 32'(fe_b), 32'd0);
      chk("lj_ovr_b", 32'(ovr_b), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
